// File: rtl/game_pkg.sv
// Shared definitions for the pile-game flow controller: page encodings,
// pile geometry and small arithmetic helpers.
package game_pkg;

    localparam int          NPILE       = 10;
    localparam int          PILE_W      = 4;
    localparam int          STATUS_W    = NPILE * PILE_W;
    localparam logic [39:0] INIT_STATUS = 40'h1111111111;

    typedef enum logic [2:0] {
        PG_TITLE     = 3'd0,
        PG_HELP      = 3'd1,
        PG_SELECT    = 3'd2,
        PG_PLAY      = 3'd3,
        PG_ROUND_END = 3'd4,
        PG_RESULT    = 3'd5
    } page_e;

    // A request for zero rounds still plays a single-round match.
    function automatic logic [2:0] round_target(input logic [2:0] n);
        if (n == 3'd0) begin
            return 3'd1;
        end else begin
            return n;
        end
    endfunction

    // Win counters stop at the largest value they can hold.
    function automatic logic [2:0] sat_inc3(input logic [2:0] v);
        if (v == 3'd7) begin
            return 3'd7;
        end else begin
            return v + 3'd1;
        end
    endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Move-commit channel between the selection cursor (master) and the
// flow controller (slave).
interface game_flow_ctrl_if;
    logic       commit_valid;
    logic [3:0] commit_idx;
    logic [3:0] commit_val;
    logic       commit_ack;
    logic       commit_err;

    modport master (
        output commit_valid,
        output commit_idx,
        output commit_val,
        input  commit_ack,
        input  commit_err
    );

    modport slave (
        input  commit_valid,
        input  commit_idx,
        input  commit_val,
        output commit_ack,
        output commit_err
    );
endinterface

// File: rtl/game_flow_ctrl_pile_file.sv
// Pile register file: holds all pile nibbles, reloads them on request,
// judges whether a proposed move is legal and whether it would clear the board.
module pile_file
    import game_pkg::*;
#(
    parameter int                   NPILE       = game_pkg::NPILE,
    parameter logic [4*NPILE-1:0]   INIT_STATUS = game_pkg::INIT_STATUS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_init,
    input  logic                 load_zero,
    input  logic                 wr_en,
    input  logic [3:0]           wr_idx,
    input  logic [3:0]           wr_val,
    output logic [4*NPILE-1:0]   status,
    output logic                 legal,
    output logic                 all_zero_next
);

    logic [4*NPILE-1:0] status_r;
    logic [4*NPILE-1:0] status_wr_s;
    logic [3:0]         pile_sel_s;
    logic               idx_ok_s;

    // Read the addressed pile; out-of-range indices read as an empty pile.
    always_comb begin
        pile_sel_s = 4'd0;
        for (int i = 0; i < NPILE; i++) begin
            if (wr_idx == 4'(i)) begin
                pile_sel_s = status_r[4*i +: 4];
            end else begin
                pile_sel_s = pile_sel_s;
            end
        end
    end

    // Board as it would look after the proposed write lands.
    always_comb begin
        status_wr_s = status_r;
        for (int i = 0; i < NPILE; i++) begin
            if (wr_idx == 4'(i)) begin
                status_wr_s[4*i +: 4] = wr_val;
            end else begin
                status_wr_s[4*i +: 4] = status_wr_s[4*i +: 4];
            end
        end
    end

    // A move must target a real pile and strictly reduce it.
    always_comb begin
        idx_ok_s      = (wr_idx < 4'(NPILE));
        legal         = idx_ok_s && (wr_val < pile_sel_s);
        all_zero_next = (status_wr_s == {(4*NPILE){1'b0}});
    end

    // Pile storage: zero load wins over init load, which wins over a move write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_r <= INIT_STATUS;
        end else if (load_zero) begin
            status_r <= {(4*NPILE){1'b0}};
        end else if (load_init) begin
            status_r <= INIT_STATUS;
        end else if (wr_en) begin
            status_r <= status_wr_s;
        end else begin
            status_r <= status_r;
        end
    end

    assign status = status_r;

endmodule

// File: rtl/game_flow_ctrl.sv
// Page sequencer and turn scheduler for the two-player pile game.
// Owns the page FSM, the turn bit, round-win counters and move responses;
// pile storage and move legality live in pile_file.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int                   NPILE       = game_pkg::NPILE,
    parameter logic [4*NPILE-1:0]   INIT_STATUS = game_pkg::INIT_STATUS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 key_enter,
    input  logic                 key_space,
    input  logic                 key_esc,
    input  logic [2:0]           num_rounds,
    game_flow_ctrl_if.slave      commit_bus,
    output logic [4*NPILE-1:0]   status,
    output logic [2:0]           page,
    output logic                 player,
    output logic [2:0]           win0,
    output logic [2:0]           win1,
    output logic                 round_over,
    output logic                 match_winner
);

    page_e      page_r;
    page_e      page_next_s;
    logic       player_r;
    logic [2:0] win0_r;
    logic [2:0] win1_r;
    logic [2:0] target_r;
    logic       ack_r;
    logic       err_r;
    logic       round_over_r;
    logic       match_winner_r;

    logic       ld_init_s;
    logic       ld_zero_s;
    logic       start_s;
    logic       abort_s;
    logic       eval_s;
    logic       wr_en_s;
    logic       legal_s;
    logic       all_zero_next_s;
    logic       round_won_s;

    pile_file #(
        .NPILE       (NPILE),
        .INIT_STATUS (INIT_STATUS)
    ) u_pile_file (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_init     (ld_init_s),
        .load_zero     (ld_zero_s),
        .wr_en         (wr_en_s),
        .wr_idx        (commit_bus.commit_idx),
        .wr_val        (commit_bus.commit_val),
        .status        (status),
        .legal         (legal_s),
        .all_zero_next (all_zero_next_s)
    );

    // Page state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            page_r <= PG_TITLE;
        end else begin
            page_r <= page_next_s;
        end
    end

    // Page transitions and the pile-file load/evaluate strobes they imply.
    always_comb begin
        page_next_s = page_r;
        ld_init_s   = 1'b0;
        ld_zero_s   = 1'b0;
        start_s     = 1'b0;
        abort_s     = 1'b0;
        eval_s      = 1'b0;
        case (page_r)
            PG_TITLE: begin
                if (key_enter) begin
                    page_next_s = PG_SELECT;
                end else if (key_space) begin
                    page_next_s = PG_HELP;
                end else begin
                    page_next_s = PG_TITLE;
                end
            end
            PG_HELP: begin
                if (key_enter) begin
                    page_next_s = PG_SELECT;
                end else if (key_esc) begin
                    page_next_s = PG_TITLE;
                end else begin
                    page_next_s = PG_HELP;
                end
            end
            PG_SELECT: begin
                if (key_enter) begin
                    page_next_s = PG_PLAY;
                    start_s     = 1'b1;
                    ld_init_s   = 1'b1;
                end else if (key_esc) begin
                    page_next_s = PG_TITLE;
                end else begin
                    page_next_s = PG_SELECT;
                end
            end
            PG_PLAY: begin
                // Abort beats a same-cycle commit, which is then ignored entirely.
                if (key_esc) begin
                    page_next_s = PG_TITLE;
                    abort_s     = 1'b1;
                    ld_init_s   = 1'b1;
                end else if (commit_bus.commit_valid) begin
                    eval_s = 1'b1;
                    if (legal_s && all_zero_next_s) begin
                        page_next_s = PG_ROUND_END;
                    end else begin
                        page_next_s = PG_PLAY;
                    end
                end else begin
                    page_next_s = PG_PLAY;
                end
            end
            PG_ROUND_END: begin
                // Win counters were already bumped on the winning move's edge.
                if ((win0_r == target_r) || (win1_r == target_r)) begin
                    page_next_s = PG_RESULT;
                    ld_zero_s   = 1'b1;
                end else begin
                    page_next_s = PG_PLAY;
                    ld_init_s   = 1'b1;
                end
            end
            PG_RESULT: begin
                if (key_enter || key_esc) begin
                    page_next_s = PG_TITLE;
                    ld_init_s   = 1'b1;
                end else begin
                    page_next_s = PG_RESULT;
                    ld_zero_s   = 1'b1;
                end
            end
            default: begin
                page_next_s = PG_TITLE;
                ld_init_s   = 1'b1;
            end
        endcase
    end

    // A commit only modifies the board when it was evaluated and found legal.
    always_comb begin
        wr_en_s     = eval_s && legal_s;
        round_won_s = eval_s && legal_s && all_zero_next_s;
    end

    // Round target is latched only when a match starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_r <= 3'd1;
        end else if (start_s) begin
            target_r <= round_target(num_rounds);
        end else begin
            target_r <= target_r;
        end
    end

    // Turn bit and win counters; the loser of a round opens the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            player_r       <= 1'b0;
            win0_r         <= 3'd0;
            win1_r         <= 3'd0;
            match_winner_r <= 1'b0;
        end else if (start_s || abort_s) begin
            player_r       <= 1'b0;
            win0_r         <= 3'd0;
            win1_r         <= 3'd0;
            match_winner_r <= match_winner_r;
        end else if (wr_en_s) begin
            player_r <= ~player_r;
            if (round_won_s) begin
                match_winner_r <= player_r;
                if (player_r == 1'b0) begin
                    win0_r <= sat_inc3(win0_r);
                    win1_r <= win1_r;
                end else begin
                    win0_r <= win0_r;
                    win1_r <= sat_inc3(win1_r);
                end
            end else begin
                match_winner_r <= match_winner_r;
                win0_r         <= win0_r;
                win1_r         <= win1_r;
            end
        end else begin
            player_r       <= player_r;
            win0_r         <= win0_r;
            win1_r         <= win1_r;
            match_winner_r <= match_winner_r;
        end
    end

    // One-cycle move responses, registered one clock after the commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_r        <= 1'b0;
            err_r        <= 1'b0;
            round_over_r <= 1'b0;
        end else begin
            ack_r        <= eval_s && legal_s;
            err_r        <= eval_s && !legal_s;
            round_over_r <= round_won_s;
        end
    end

    assign page                  = page_r;
    assign player                = player_r;
    assign win0                  = win0_r;
    assign win1                  = win1_r;
    assign round_over            = round_over_r;
    assign match_winner          = match_winner_r;
    assign commit_bus.commit_ack = ack_r;
    assign commit_bus.commit_err = err_r;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: directed scenarios followed by
// randomized key/commit traffic, all compared against a behavioural model.
module tb_game_flow_ctrl;
    import game_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        key_enter;
    logic        key_space;
    logic        key_esc;
    logic [2:0]  num_rounds;
    logic [39:0] status;
    logic [2:0]  page;
    logic        player;
    logic [2:0]  win0;
    logic [2:0]  win1;
    logic        round_over;
    logic        match_winner;

    game_flow_ctrl_if bus ();

    game_flow_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_enter    (key_enter),
        .key_space    (key_space),
        .key_esc      (key_esc),
        .num_rounds   (num_rounds),
        .commit_bus   (bus),
        .status       (status),
        .page         (page),
        .player       (player),
        .win0         (win0),
        .win1         (win1),
        .round_over   (round_over),
        .match_winner (match_winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: pages as ints, piles as an integer array.
    int m_page;
    int m_pile [10];
    int m_player;
    int m_w0, m_w1, m_target;
    int m_ack, m_err, m_ro, m_mw;

    task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [39:0] m_status();
        logic [39:0] s;
        s = 40'h0;
        for (int i = 0; i < 10; i++) s[4*i +: 4] = m_pile[i][3:0];
        return s;
    endfunction

    task automatic fill_piles(input int v);
        for (int i = 0; i < 10; i++) m_pile[i] = v;
    endtask

    task automatic model_reset();
        m_page = 0; fill_piles(1); m_player = 0;
        m_w0 = 0; m_w1 = 0; m_target = 1;
        m_ack = 0; m_err = 0; m_ro = 0; m_mw = 0;
    endtask

    // One clock edge of the game rules.
    task automatic model_edge(input bit e, input bit s, input bit x, input bit cv,
                              input int ci, input int cval, input int nr);
        int sum;
        bit legal;
        m_ack = 0; m_err = 0; m_ro = 0;
        if (m_page == 0) begin
            if (e) m_page = 2; else if (s) m_page = 1;
        end else if (m_page == 1) begin
            if (e) m_page = 2; else if (x) m_page = 0;
        end else if (m_page == 2) begin
            if (e) begin
                m_page = 3; m_target = (nr == 0) ? 1 : nr;
                fill_piles(1); m_w0 = 0; m_w1 = 0; m_player = 0;
            end else if (x) m_page = 0;
        end else if (m_page == 3) begin
            if (x) begin
                m_page = 0; fill_piles(1); m_w0 = 0; m_w1 = 0; m_player = 0;
            end else if (cv) begin
                legal = (ci < 10) ? (cval < m_pile[ci]) : 1'b0;
                if (legal) begin
                    m_pile[ci] = cval;
                    m_ack = 1;
                    sum = 0;
                    for (int i = 0; i < 10; i++) sum += m_pile[i];
                    if (sum == 0) begin
                        if (m_player == 0) m_w0 = (m_w0 < 7) ? m_w0 + 1 : 7;
                        else               m_w1 = (m_w1 < 7) ? m_w1 + 1 : 7;
                        m_ro = 1; m_mw = m_player; m_page = 4;
                    end
                    m_player = 1 - m_player;
                end else begin
                    m_err = 1;
                end
            end
        end else if (m_page == 4) begin
            if (m_w0 == m_target || m_w1 == m_target) begin
                m_page = 5; fill_piles(0);
            end else begin
                m_page = 3; fill_piles(1);
            end
        end else if (m_page == 5) begin
            if (e || x) begin m_page = 0; fill_piles(1); end
        end
    endtask

    task automatic check_all();
        chk("page",       {37'h0, page},         40'(m_page));
        chk("status",     status,                m_status());
        chk("player",     {39'h0, player},       40'(m_player));
        chk("win0",       {37'h0, win0},         40'(m_w0));
        chk("win1",       {37'h0, win1},         40'(m_w1));
        chk("commit_ack", {39'h0, bus.commit_ack}, 40'(m_ack));
        chk("commit_err", {39'h0, bus.commit_err}, 40'(m_err));
        chk("round_over", {39'h0, round_over},   40'(m_ro));
        if (m_page == 5) chk("match_winner", {39'h0, match_winner}, 40'(m_mw));
    endtask

    task automatic step(input bit e, input bit s, input bit x, input bit cv,
                        input logic [3:0] ci, input logic [3:0] cval);
        key_enter = e; key_space = s; key_esc = x;
        bus.commit_valid = cv; bus.commit_idx = ci; bus.commit_val = cval;
        @(posedge clk);
        model_edge(e, s, x, cv, int'(ci), int'(cval), int'(num_rounds));
        #1;
        check_all();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    endtask

    task automatic do_reset_mid();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_page",   {37'h0, page}, 40'd0);
        chk("rst_status", status, 40'h1111111111);
        chk("rst_player", {39'h0, player}, 40'd0);
        chk("rst_wins",   {34'h0, win0, win1}, 40'd0);
        chk("rst_pulses", {37'h0, bus.commit_ack, bus.commit_err, round_over}, 40'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit e, s, x, cv;
        logic [3:0] ci, cval;
        rst_n = 1'b0; key_enter = 1'b0; key_space = 1'b0; key_esc = 1'b0;
        num_rounds = 3'd2;
        bus.commit_valid = 1'b0; bus.commit_idx = 4'd0; bus.commit_val = 4'd0;
        model_reset();
        #12;
        chk("reset_page", {37'h0, page}, 40'd0);
        chk("reset_match_winner", {39'h0, match_winner}, 40'd0);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // 1: page walk to PLAY
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        chk("t1_help", {37'h0, page}, 40'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        chk("t1_title", {37'h0, page}, 40'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        chk("t1_select", {37'h0, page}, 40'd2);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        chk("t1_play", {37'h0, page}, 40'd3);
        chk("t1_status", status, 40'h1111111111);

        // 2: legal then repeated move
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 4'd0);
        chk("t2_status", status, 40'h1111110111);
        chk("t2_ack", {39'h0, bus.commit_ack}, 40'd1);
        chk("t2_player", {39'h0, player}, 40'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 4'd0);
        chk("t2_err", {39'h0, bus.commit_err}, 40'd1);
        chk("t2_hold", status, 40'h1111110111);

        // 3: bad index, non-reducing value
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'd12, 4'd0);
        chk("t3_err_idx", {39'h0, bus.commit_err}, 40'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd1);
        chk("t3_err_val", {39'h0, bus.commit_err}, 40'd1);

        // 4: finish the round, player 1 takes the last pile
        for (int i = 0; i < 10; i++) begin
            if (i != 3) step(1'b0, 1'b0, 1'b0, 1'b1, 4'(i), 4'd0);
        end
        chk("t4_win1", {37'h0, win1}, 40'd1);
        chk("t4_round_over", {39'h0, round_over}, 40'd1);
        chk("t4_round_end", {37'h0, page}, 40'd4);
        idle();
        chk("t4_play", {37'h0, page}, 40'd3);
        chk("t4_reload", status, 40'h1111111111);
        chk("t4_player", {39'h0, player}, 40'd0);

        // 5: single-round match won by player 1
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        num_rounds = 3'd1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 4'(i), 4'd0);
        idle();
        chk("t5_result", {37'h0, page}, 40'd5);
        chk("t5_winner", {39'h0, match_winner}, 40'd1);
        chk("t5_zero", status, 40'h0);
        idle();
        chk("t5_hold_zero", status, 40'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        chk("t5_title", {37'h0, page}, 40'd0);

        // 6: esc beats commit; async reset mid-play
        num_rounds = 3'd3;
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0);
        chk("t6_title", {37'h0, page}, 40'd0);
        chk("t6_no_resp", {38'h0, bus.commit_ack, bus.commit_err}, 40'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 4'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'd6, 4'd0);
        do_reset_mid();

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            num_rounds = 3'($urandom_range(0, 7));
            e  = ($urandom_range(0, 19) == 0);
            s  = ($urandom_range(0, 9) == 0);
            x  = (m_page == 3) ? ($urandom_range(0, 399) == 0) : ($urandom_range(0, 29) == 0);
            cv = ($urandom_range(0, 1) == 1);
            ci   = 4'($urandom_range(0, 11));
            cval = 4'($urandom_range(0, 2));
            step(e, s, x, cv, ci, cval);
            if (c == 2500) do_reset_mid();
        end

        key_enter = 1'b0; key_space = 1'b0; key_esc = 1'b0; bus.commit_valid = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
